// File: rtl/msdf_digit_collector.sv
`default_nettype none
// ============================================================================
// Module   : msdf_digit_collector
// Brief    : Collects an MSB-first signed-digit (plus/minus) stream, one frame
//            at a time, and presents the frame as a parallel two's-complement
//            word over a valid/ready handshake. Digit i (first digit is i=0)
//            has weight 2^-(i+1); result value = dataOutArray_0 / 2^DIGITS.
//            Optional feature macro: MSDF_COLLECT_OVF_EN adds the truncation
//            flag port ovfArray_0.
// Revision : 1.0 - initial release
// ============================================================================
module msdf_digit_collector #(
    parameter int DIGITS = 32,
    parameter int OUT_W  = DIGITS + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       dataInArray_0,
    input  logic             pValidArray_0,
    output logic             readyArray_0,
    output logic [OUT_W-1:0] dataOutArray_0,
    output logic             validArray_0,
    input  logic             nReadyArray_0
`ifdef MSDF_COLLECT_OVF_EN
    ,
    output logic             ovfArray_0
`endif
);

    localparam int c_PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_CNT_W = $clog2(DIGITS + 1);

    localparam logic [c_PTR_W-1:0] c_PTR_TOP  = c_PTR_W'(DIGITS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DIGITS);

    localparam logic [0:0] c_ST_COLLECT = 1'b0;
    localparam logic [0:0] c_ST_HOLD    = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [DIGITS-1:0]  r_p;
    logic [DIGITS-1:0]  r_m;
    logic [DIGITS-1:0]  w_p_next;
    logic [DIGITS-1:0]  w_m_next;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [DIGITS:0]    w_result;
    logic [OUT_W-1:0]   r_data;

    logic w_accept;
    logic w_room;
    logic w_store;
    logic w_last;
    logic w_handoff;

    // Handshake qualifiers derived from the current state and inputs
    assign w_accept  = pValidArray_0 & (r_state == c_ST_COLLECT);
    assign w_room    = (r_count != c_CNT_FULL);
    assign w_store   = w_accept & w_room;
    assign w_last    = w_accept & dataInArray_0[2];
    assign w_handoff = (r_state == c_ST_HOLD) & nReadyArray_0;

    // Digit vectors including the digit being accepted this cycle
    always_comb begin
        w_p_next = r_p;
        w_m_next = r_m;
        if (w_store) begin
            w_p_next[r_wr_ptr] = dataInArray_0[1];
            w_m_next[r_wr_ptr] = dataInArray_0[0];
        end
    end

    // P and M are unsigned magnitudes; one extra bit keeps P-M in range
    assign w_result = {1'b0, w_p_next} - {1'b0, w_m_next};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt  = r_state;
        readyArray_0 = 1'b0;
        validArray_0 = 1'b0;
        case (r_state)
            c_ST_COLLECT: begin
                readyArray_0 = 1'b1;
                if (w_last) begin
                    w_state_nxt = c_ST_HOLD;
                end
            end
            default: begin
                validArray_0 = 1'b1;
                if (nReadyArray_0) begin
                    w_state_nxt = c_ST_COLLECT;
                end
            end
        endcase
    end

    // Digit storage, write pointer and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p      <= '0;
            r_m      <= '0;
            r_wr_ptr <= c_PTR_TOP;
            r_count  <= '0;
            r_data   <= '0;
        end else if (w_handoff) begin
            // Start a fresh frame; the last result stays visible
            r_p      <= '0;
            r_m      <= '0;
            r_wr_ptr <= c_PTR_TOP;
            r_count  <= '0;
        end else begin
            if (w_store) begin
                r_p      <= w_p_next;
                r_m      <= w_m_next;
                r_wr_ptr <= r_wr_ptr - c_PTR_W'(1);
                r_count  <= r_count + c_CNT_W'(1);
            end
            if (w_last) begin
                r_data <= OUT_W'(w_result);
            end
        end
    end

    assign dataOutArray_0 = r_data;

`ifdef MSDF_COLLECT_OVF_EN
    logic w_trunc;
    logic r_ovf_lat;
    logic r_ovf_out;

    assign w_trunc = w_accept & ~w_room;

    // Truncation latch for the frame in progress and flag published with the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_lat <= 1'b0;
            r_ovf_out <= 1'b0;
        end else if (w_handoff) begin
            r_ovf_lat <= 1'b0;
            r_ovf_out <= 1'b0;
        end else begin
            if (w_trunc) begin
                r_ovf_lat <= 1'b1;
            end
            if (w_last) begin
                r_ovf_out <= r_ovf_lat | w_trunc;
            end
        end
    end

    assign ovfArray_0 = r_ovf_out;
`endif

endmodule
`default_nettype wire

// File: tb/tb_msdf_digit_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_msdf_digit_collector
// Brief    : Self-checking bench for msdf_digit_collector (DIGITS=8). Frames
//            are described as digit lists and the expected word is computed
//            as a plain weighted sum of the digit values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msdf_digit_collector;

    localparam int c_DIGITS = 8;
    localparam int c_OUT_W  = c_DIGITS + 1;

    logic               clk;
    logic               rst;
    logic [2:0]         dataInArray_0;
    logic               pValidArray_0;
    logic               readyArray_0;
    logic [c_OUT_W-1:0] dataOutArray_0;
    logic               validArray_0;
    logic               nReadyArray_0;
`ifdef MSDF_COLLECT_OVF_EN
    logic               ovfArray_0;
`endif

    msdf_digit_collector #(
        .DIGITS (c_DIGITS),
        .OUT_W  (c_OUT_W)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .dataInArray_0  (dataInArray_0),
        .pValidArray_0  (pValidArray_0),
        .readyArray_0   (readyArray_0),
        .dataOutArray_0 (dataOutArray_0),
        .validArray_0   (validArray_0),
        .nReadyArray_0  (nReadyArray_0)
`ifdef MSDF_COLLECT_OVF_EN
        ,
        .ovfArray_0     (ovfArray_0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit done     = 1'b0;

    // Current frame: each entry is {plus, minus}
    logic [1:0] fr [0:15];
    int         fr_len;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: weighted sum of the first DIGITS digit values, wrapped to OUT_W bits
    function automatic logic [c_OUT_W-1:0] model_value();
        int acc = 0;
        for (int i = 0; i < fr_len && i < c_DIGITS; i++) begin
            acc += (int'(fr[i][1]) - int'(fr[i][0])) * (1 << (c_DIGITS - 1 - i));
        end
        return c_OUT_W'(acc);
    endfunction

    // Feed the frame digits; flag the final one as last when close is set
    task automatic send_frame(input bit close, input bit gaps);
        for (int i = 0; i < fr_len; i++) begin
            @(negedge clk);
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                pValidArray_0 = 1'b0;
                dataInArray_0 = 3'($urandom);
                @(posedge clk);
                @(negedge clk);
                check_val("ready_idle", 32'(readyArray_0), 32'd1);
            end
            dataInArray_0 = {(close && i == fr_len - 1), fr[i]};
            pValidArray_0 = 1'b1;
            @(posedge clk);
        end
    endtask

    // Check the result, stall downstream with a held upstream digit, then hand off
    task automatic finish_frame(input int stall);
        logic [c_OUT_W-1:0] exp_v;
        exp_v = model_value();
        @(negedge clk);
        check_val("valid_n1", 32'(validArray_0), 32'd1);
        check_val("data", 32'(dataOutArray_0), 32'(exp_v));
        check_val("ready_hold", 32'(readyArray_0), 32'd0);
`ifdef MSDF_COLLECT_OVF_EN
        check_val("ovf", 32'(ovfArray_0), 32'(fr_len > c_DIGITS));
`endif
        // Upstream offers a non-last +1 digit that must not be consumed
        dataInArray_0 = 3'b010;
        pValidArray_0 = 1'b1;
        nReadyArray_0 = 1'b0;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            @(negedge clk);
            check_val("stall_valid", 32'(validArray_0), 32'd1);
            check_val("stall_data", 32'(dataOutArray_0), 32'(exp_v));
            check_val("stall_ready", 32'(readyArray_0), 32'd0);
        end
        nReadyArray_0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        nReadyArray_0 = 1'b0;
        pValidArray_0 = 1'b0;
        check_val("post_valid", 32'(validArray_0), 32'd0);
        check_val("post_ready", 32'(readyArray_0), 32'd1);
        check_val("post_data", 32'(dataOutArray_0), 32'(exp_v));
`ifdef MSDF_COLLECT_OVF_EN
        check_val("post_ovf", 32'(ovfArray_0), 32'd0);
`endif
    endtask

    task automatic run_frame(input int stall, input bit gaps);
        send_frame(1'b1, gaps);
        finish_frame(stall);
    endtask

    // Mid-cycle asynchronous reset; outputs must clear before any clock edge
    task automatic async_reset();
        @(negedge clk);
        pValidArray_0 = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_val("rst_valid", 32'(validArray_0), 32'd0);
        check_val("rst_data", 32'(dataOutArray_0), 32'd0);
        check_val("rst_ready", 32'(readyArray_0), 32'd1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        dataInArray_0 = 3'b000;
        pValidArray_0 = 1'b0;
        nReadyArray_0 = 1'b0;
        #12;
        check_val("reset_valid", 32'(validArray_0), 32'd0);
        check_val("reset_data", 32'(dataOutArray_0), 32'd0);
        check_val("reset_ready", 32'(readyArray_0), 32'd1);
`ifdef MSDF_COLLECT_OVF_EN
        check_val("reset_ovf", 32'(ovfArray_0), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // +1 then seven zeros -> +0.5
        fr_len = 8;
        fr[0] = 2'b10;
        for (int i = 1; i < 8; i++) fr[i] = 2'b00;
        run_frame(1, 1'b0);
        check_val("plus_half", 32'(dataOutArray_0), 32'h080);

        // -1, +1 -> -0.25, with a 5-cycle stall
        fr_len = 2;
        fr[0] = 2'b01;
        fr[1] = 2'b10;
        run_frame(5, 1'b0);
        check_val("minus_quarter", 32'(dataOutArray_0), 32'h1C0);

        // +1 as first digit after handoff must land at the top position
        fr_len = 1;
        fr[0] = 2'b10;
        run_frame(0, 1'b0);
        check_val("after_handoff", 32'(dataOutArray_0), 32'h080);

        // 10 digits of +1 -> truncated to 0x0FF
        fr_len = 10;
        for (int i = 0; i < 10; i++) fr[i] = 2'b10;
        run_frame(2, 1'b0);
        check_val("trunc_all_ones", 32'(dataOutArray_0), 32'h0FF);

        // Eight 11 digits -> zero
        fr_len = 8;
        for (int i = 0; i < 8; i++) fr[i] = 2'b11;
        run_frame(0, 1'b0);
        check_val("all_11", 32'(dataOutArray_0), 32'h000);

        // Reset after three digits, then a fresh one-digit frame
        fr_len = 3;
        fr[0] = 2'b10; fr[1] = 2'b01; fr[2] = 2'b10;
        send_frame(1'b0, 1'b0);
        async_reset();
        fr_len = 1;
        fr[0] = 2'b10;
        run_frame(1, 1'b0);
        check_val("after_reset", 32'(dataOutArray_0), 32'h080);

        // Reset while holding a result
        fr_len = 2;
        fr[0] = 2'b10; fr[1] = 2'b10;
        send_frame(1'b1, 1'b0);
        @(negedge clk);
        check_val("pre_rst_data", 32'(dataOutArray_0), 32'h0C0);
        async_reset();

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            fr_len = $urandom_range(1, 12);
            for (int i = 0; i < fr_len; i++) fr[i] = 2'($urandom_range(0, 3));
            run_frame($urandom_range(0, 4), 1'b1);
        end

        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Bound on total run time
    initial begin
        #200000;
        if (!done) begin
            $display("FAIL timeout: got running expected finished");
            $fatal(1);
        end
    end

endmodule
`default_nettype wire
